// File: rtl/rwc_pkg.sv
// Shared types and constants for the rwc_sched challenge scheduler.
package rwc_pkg;

  localparam int unsigned RWC_ADDR_W = 10;
  localparam int unsigned RWC_DATA_W = 32;

  localparam logic [RWC_DATA_W-1:0] RWC_LFSR_TAPS = 32'h8020_0003;
  localparam logic [RWC_DATA_W-1:0] RWC_SEED_ZERO = 32'h0000_0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_ACCUM,
    S_EMIT
  } rwc_state_t;

  // One right-shifting Galois step of the challenge LFSR.
  function automatic logic [RWC_DATA_W-1:0] lfsr_step(input logic [RWC_DATA_W-1:0] s,
                                                      input logic [RWC_DATA_W-1:0] taps);
    lfsr_step = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage

// File: rtl/rwc_vote.sv
// Per-bit-lane flip counters with a majority output that includes the current sample.
module rwc_vote
  import rwc_pkg::*;
#(
  parameter int unsigned REPEAT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  acc,
  input  logic [RWC_DATA_W-1:0] flip,
  output logic [RWC_DATA_W-1:0] maj_c
);

  localparam int unsigned CNT_W = $clog2(REPEAT + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q [RWC_DATA_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(RWC_DATA_W); i++) begin
      if (rst || clr) begin
        cnt_q[i] <= '0;
      end else if (acc) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(flip[i]);
      end
    end
  end

  always_comb begin
    maj_c = '0;
    for (int i = 0; i < int'(RWC_DATA_W); i++) begin
      maj_c[i] = (SUM_W'(cnt_q[i]) + SUM_W'(acc & flip[i])) > SUM_W'(REPEAT / 2);
    end
  end

endmodule

// File: rtl/rwc_sched.sv
// Batch challenge scheduler: walks a BRAM window, majority-votes REPEAT generator runs per address.
// Optional watchdog enabled by defining RWC_SCHED_WATCHDOG_EN.
module rwc_sched
  import rwc_pkg::*;
#(
  parameter int unsigned            REPEAT      = 5,
  parameter logic [RWC_DATA_W-1:0]  LFSR_TAPS   = RWC_LFSR_TAPS,
  parameter int unsigned            TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [RWC_ADDR_W-1:0] base_addr,
  input  logic [RWC_ADDR_W-1:0] num_chal,
  input  logic [RWC_DATA_W-1:0] seed,
  output logic                  busy,
  output logic                  gen_enable,
  output logic [RWC_DATA_W-1:0] cha_data,
  output logic [RWC_ADDR_W-1:0] cha_addr,
  input  logic                  available,
  input  logic [RWC_DATA_W-1:0] rsp_write,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RWC_DATA_W-1:0] rsp_data,
  output logic [RWC_ADDR_W-1:0] rsp_addr,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(REPEAT + 1);

  if ((REPEAT % 2) == 0 || REPEAT < 1 || REPEAT > 15) begin : g_bad_repeat
    $error("rwc_sched: REPEAT must be odd and in 1..15");
  end

  rwc_state_t            state_q, state_d;
  logic                  busy_d, gen_enable_d, rsp_valid_d;
  logic [RWC_DATA_W-1:0] cha_data_d, rsp_data_d, lfsr_q, lfsr_d, lfsr_adv_c;
  logic [RWC_ADDR_W-1:0] cha_addr_d, rsp_addr_d, base_q, base_d, num_q, num_d, idx_q, idx_d;
  logic [CNT_W-1:0]      rep_q, rep_d, rep_inc_c;
  logic [RWC_DATA_W-1:0] seed_c, flip_c, maj_c;
  logic                  vote_clr, vote_acc, timeout_c;

  assign seed_c     = (seed == '0) ? RWC_SEED_ZERO : seed;
  assign flip_c     = rsp_write ^ cha_data;
  assign lfsr_adv_c = lfsr_step(lfsr_q, LFSR_TAPS);
  assign rep_inc_c  = rep_q + CNT_W'(1);

  rwc_vote #(.REPEAT(REPEAT)) u_vote (
    .clk   (clk),
    .rst   (rst),
    .clr   (vote_clr),
    .acc   (vote_acc),
    .flip  (flip_c),
    .maj_c (maj_c)
  );

`ifdef RWC_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;
  logic            stay_c;

  // A waiting state that does not advance this cycle keeps the watchdog running.
  assign stay_c = ((state_q == S_ISSUE)   && !available) ||
                  ((state_q == S_WAIT_LO) &&  available) ||
                  ((state_q == S_WAIT_HI) && !available);
  assign timeout_c = stay_c && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
      err  <= 1'b0;
    end else begin
      wd_q <= (stay_c && !timeout_c) ? wd_q + WD_W'(1) : '0;
      if (timeout_c) err <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy       <= 1'b0;
      gen_enable <= 1'b0;
      cha_data   <= '0;
      cha_addr   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      base_q     <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      lfsr_q     <= '0;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= busy_d;
      gen_enable <= gen_enable_d;
      cha_data   <= cha_data_d;
      cha_addr   <= cha_addr_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_addr   <= rsp_addr_d;
      base_q     <= base_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      rep_q      <= rep_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy;
    gen_enable_d = 1'b0;
    cha_data_d   = cha_data;
    cha_addr_d   = cha_addr;
    rsp_valid_d  = rsp_valid;
    rsp_data_d   = rsp_data;
    rsp_addr_d   = rsp_addr;
    base_d       = base_q;
    num_d        = num_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    rep_d        = rep_q;
    vote_clr     = 1'b0;
    vote_acc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          num_d      = num_chal;
          idx_d      = '0;
          lfsr_d     = seed_c;
          cha_addr_d = base_addr;
          cha_data_d = seed_c;
          rep_d      = '0;
          vote_clr   = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (available) begin
          gen_enable_d = 1'b1;
          state_d      = S_WAIT_LO;
        end
      end
      S_WAIT_LO: if (!available) state_d = S_WAIT_HI;
      S_WAIT_HI: if (available)  state_d = S_ACCUM;
      S_ACCUM: begin
        vote_acc = 1'b1;
        rep_d    = rep_inc_c;
        if (rep_inc_c < CNT_W'(REPEAT)) begin
          state_d = S_ISSUE;
        end else begin
          rsp_data_d  = maj_c;
          rsp_addr_d  = cha_addr;
          rsp_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          vote_clr    = 1'b1;
          rep_d       = '0;
          lfsr_d      = lfsr_adv_c;
          if (idx_q == num_q) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d      = idx_q + RWC_ADDR_W'(1);
            cha_addr_d = RWC_ADDR_W'(base_q + idx_q + RWC_ADDR_W'(1));
            cha_data_d = lfsr_adv_c;
            state_d    = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Generator never answered: abandon the batch without emitting.
    if (timeout_c) begin
      gen_enable_d = 1'b0;
      busy_d       = 1'b0;
      rep_d        = '0;
      vote_clr     = 1'b1;
      state_d      = S_IDLE;
    end
  end

endmodule
